// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: requester owner tags,
// lock-state encoding and the default outstanding-transaction depth.
package sram_port_arbiter_pkg;

  localparam int OUTSTANDING_DEF = 4;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_owner_fifo.sv
// In-order owner FIFO: one owner tag per accepted address phase, popped
// when the matching data beat returns. A push into a full FIFO is blocked
// unless a pop happens in the same cycle.
module arb_owner_fifo
  import sram_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF,
  parameter int PTR_W       = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  owner_e       din,
  output owner_e       dout,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count
);

  owner_e             slot_q [OUTSTANDING];
  owner_e             slot_d [OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(OUTSTANDING));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = slot_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Next-state for storage, pointers (wrap naturally at power-of-two depth) and occupancy
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      slot_d[wr_ptr_q] = din;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage carries no reset; occupancy decides validity
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one addr_ok/data_ok SRAM-like port between the fetch and data
// requesters. Fixed data-over-inst priority by default; define ARB_RR_EN
// for round-robin arbitration. A grant is held (LOCK) until mem_addr_ok.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF,
  parameter int OWN_PTR_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_e         state_q, state_d;
  owner_e             lock_own_q, lock_own_d;
  owner_e             grant, head;
  logic               gnt_req, can_push, push, pop_ok;
  logic               fifo_full, fifo_empty;
  logic [OWN_PTR_W:0] owner_cnt;
  logic [31:0]        inst_rdata_q, inst_rdata_d;
  logic [31:0]        data_rdata_q, data_rdata_d;
  logic               proto_err_q, proto_err_d;
`ifdef ARB_RR_EN
  owner_e             rr_q, rr_d;
`endif

  arb_owner_fifo #(
    .OUTSTANDING (OUTSTANDING),
    .PTR_W       (OWN_PTR_W)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_ok),
    .din   (grant),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (owner_cnt)
  );

  assign pop_ok   = mem_data_ok & ~fifo_empty & ~reset;
  assign can_push = ~fifo_full | pop_ok;

  // Grant selection: frozen while locked, otherwise arbitrate between requesters
  always_comb begin
    grant   = OWNER_DATA;
    gnt_req = 1'b0;
    if (state_q == ARB_LOCK) begin
      grant   = lock_own_q;
      gnt_req = (lock_own_q == OWNER_DATA) ? data_req : inst_req;
    end else begin
`ifdef ARB_RR_EN
      if (data_req && inst_req) grant = rr_q;
      else if (inst_req)        grant = OWNER_INST;
      else                      grant = OWNER_DATA;
`else
      grant = (inst_req && !data_req) ? OWNER_INST : OWNER_DATA;
`endif
      gnt_req = data_req | inst_req;
    end
  end

  assign mem_req   = gnt_req & can_push & ~reset;
  assign mem_wr    = (grant == OWNER_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (grant == OWNER_DATA) ? data_size  : inst_size;
  assign mem_wstrb = (grant == OWNER_DATA) ? data_wstrb : inst_wstrb;
  assign mem_addr  = (grant == OWNER_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (grant == OWNER_DATA) ? data_wdata : inst_wdata;

  assign push         = mem_req & mem_addr_ok;
  assign inst_addr_ok = push & (grant == OWNER_INST);
  assign data_addr_ok = push & (grant == OWNER_DATA);

  assign inst_data_ok = pop_ok & (head == OWNER_INST);
  assign data_data_ok = pop_ok & (head == OWNER_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : inst_rdata_q;
  assign data_rdata   = data_data_ok ? mem_rdata : data_rdata_q;

  // Lock tracking, read-data hold registers, protocol error flag, RR pointer
  always_comb begin
    state_d      = ARB_IDLE;
    lock_own_d   = lock_own_q;
    if (mem_req && !mem_addr_ok) begin
      state_d    = ARB_LOCK;
      lock_own_d = grant;
    end
    inst_rdata_d = inst_rdata;
    data_rdata_d = data_rdata;
    proto_err_d  = proto_err_q | (mem_data_ok & (owner_cnt == '0));
`ifdef ARB_RR_EN
    rr_d = rr_q;
    if (push) rr_d = (grant == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
`endif
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      lock_own_q   <= OWNER_DATA;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      proto_err_q  <= 1'b0;
`ifdef ARB_RR_EN
      rr_q         <= OWNER_DATA;
`endif
    end else begin
      state_q      <= state_d;
      lock_own_q   <= lock_own_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      proto_err_q  <= proto_err_d;
`ifdef ARB_RR_EN
      rr_q         <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (default fixed-priority build).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int total = 0;
  int bad   = 0;

  sram_port_arbiter #(.OUTSTANDING(4), .OWN_PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a new cycle: wait past the edge and return all inputs to idle
  task automatic step();
    @(posedge clk);
    #1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // One return beat; exp_data selects which requester should receive it
  task automatic beat(input string tag, input bit exp_data, input logic [31:0] rd);
    step();
    mem_data_ok = 1; mem_rdata = rd;
    samp();
    chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(!exp_data));
    chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(exp_data));
    if (exp_data) chk({tag, "_data_rdata"}, data_rdata, rd);
    else          chk({tag, "_inst_rdata"}, inst_rdata, rd);
  endtask

  initial begin
    reset = 1;
    step();
    step();
    samp();
    @(posedge clk); #1;
    reset = 0;
    samp();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_count", 32'(dut.owner_cnt), 0);
    chk("rst_proto_err", 32'(dut.proto_err_q), 0);

    // Single fetch
    step();
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    samp();
    chk("f_mem_req", 32'(mem_req), 1);
    chk("f_mem_addr", mem_addr, 32'h1c000000);
    chk("f_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("f_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    samp();
    chk("f_wait_data_ok", 32'(inst_data_ok), 0);
    beat("f_ret", 0, 32'h02800c0c);
    step();
    samp();
    chk("f_hold_inst_rdata", inst_rdata, 32'h02800c0c);
    chk("f_data_rdata_quiet", data_rdata, 0);

    // Contention: data wins, inst next cycle
    step();
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_addr = 32'h1c008000; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hcafef00d;
    mem_addr_ok = 1;
    samp();
    chk("c_data_addr_ok", 32'(data_addr_ok), 1);
    chk("c_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("c_mem_addr", mem_addr, 32'h1c008000);
    chk("c_mem_wr", 32'(mem_wr), 1);
    chk("c_mem_wstrb", 32'(mem_wstrb), 32'hF);
    chk("c_mem_wdata", mem_wdata, 32'hcafef00d);
    step();
    inst_req = 1; inst_addr = 32'h1c000004; mem_addr_ok = 1;
    samp();
    chk("c2_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("c2_mem_addr", mem_addr, 32'h1c000004);
    chk("c2_mem_wr", 32'(mem_wr), 0);
    beat("c_ret0", 1, 32'h000000aa);
    beat("c_ret1", 0, 32'h000000bb);

    // Lock on data: addr_ok low for 3 cycles, inst rises in cycle 2
    step();
    data_req = 1; data_addr = 32'h1c008000;
    samp();
    chk("l1_mem_addr", mem_addr, 32'h1c008000);
    chk("l1_data_addr_ok", 32'(data_addr_ok), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      data_req = 1; data_addr = 32'h1c008000; inst_req = 1; inst_addr = 32'h1c000008;
      samp();
      chk("l23_mem_addr", mem_addr, 32'h1c008000);
      chk("l23_inst_addr_ok", 32'(inst_addr_ok), 0);
    end
    step();
    data_req = 1; data_addr = 32'h1c008000; inst_req = 1; inst_addr = 32'h1c000008; mem_addr_ok = 1;
    samp();
    chk("l4_data_addr_ok", 32'(data_addr_ok), 1);
    chk("l4_inst_addr_ok", 32'(inst_addr_ok), 0);
    step();
    inst_req = 1; inst_addr = 32'h1c000008; mem_addr_ok = 1;
    samp();
    chk("l5_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("l5_mem_addr", mem_addr, 32'h1c000008);

    // Lock on inst: data must not steal the frozen grant
    step();
    inst_req = 1; inst_addr = 32'h1c00000c;
    samp();
    chk("li1_mem_addr", mem_addr, 32'h1c00000c);
    step();
    inst_req = 1; inst_addr = 32'h1c00000c; data_req = 1; data_addr = 32'h1c008004;
    samp();
    chk("li2_mem_addr", mem_addr, 32'h1c00000c);
    chk("li2_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    inst_req = 1; inst_addr = 32'h1c00000c; data_req = 1; data_addr = 32'h1c008004; mem_addr_ok = 1;
    samp();
    chk("li3_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("li3_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    data_req = 1; data_addr = 32'h1c008004; mem_addr_ok = 1;
    samp();
    chk("li4_data_addr_ok", 32'(data_addr_ok), 1);

    // FIFO now holds D,I,I,D and is full
    step();
    samp();
    chk("full_count", 32'(dut.owner_cnt), 4);
    step();
    inst_req = 1; inst_addr = 32'h1c000010; mem_addr_ok = 1;
    samp();
    chk("full_mem_req", 32'(mem_req), 0);
    chk("full_inst_addr_ok", 32'(inst_addr_ok), 0);
    step();
    inst_req = 1; inst_addr = 32'h1c000010; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h5;
    samp();
    chk("fp_mem_req", 32'(mem_req), 1);
    chk("fp_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("fp_data_data_ok", 32'(data_data_ok), 1);
    chk("fp_data_rdata", data_rdata, 32'h5);
    step();
    samp();
    chk("fp_count", 32'(dut.owner_cnt), 4);
    // Remaining order: I,I,D,I
    beat("fd0", 0, 32'h1);
    beat("fd1", 0, 32'h2);
    beat("fd2", 1, 32'h3);
    beat("fd3", 0, 32'h4);

    // Ordering: accept I,D,I,D then return 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      step();
      mem_addr_ok = 1;
      if (i % 2 == 0) begin inst_req = 1; inst_addr = 32'h1c000100 + 32'(i * 4); end
      else            begin data_req = 1; data_addr = 32'h1c008100 + 32'(i * 4); end
    end
    beat("o0", 0, 32'h11);
    beat("o1", 1, 32'h22);
    beat("o2", 0, 32'h33);
    beat("o3", 1, 32'h44);
    step();
    samp();
    chk("o_hold_inst", inst_rdata, 32'h33);
    chk("o_hold_data", data_rdata, 32'h44);
    chk("o_proto_err", 32'(dut.proto_err_q), 0);

    // Reset with 3 outstanding, then a stray data_ok
    for (int i = 0; i < 3; i++) begin
      step();
      inst_req = 1; inst_addr = 32'h1c000200 + 32'(i * 4); mem_addr_ok = 1;
    end
    step();
    reset = 1; inst_req = 1; inst_addr = 32'h1c000300; mem_addr_ok = 1;
    samp();
    chk("r_mem_req", 32'(mem_req), 0);
    chk("r_inst_addr_ok", 32'(inst_addr_ok), 0);
    step();
    reset = 0; mem_data_ok = 1; mem_rdata = 32'h99;
    samp();
    chk("r_inst_data_ok", 32'(inst_data_ok), 0);
    chk("r_data_data_ok", 32'(data_data_ok), 0);
    chk("r_inst_rdata", inst_rdata, 0);
    step();
    samp();
    chk("r_proto_err", 32'(dut.proto_err_q), 1);
    chk("r_count", 32'(dut.owner_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
